// File: rtl/axi_llc_refill_ar_master.sv
// LLC refill request stage: issues one line-sized AR burst per refill
// descriptor and forwards every descriptor in order to the R refill unit.
package axi_llc_refill_ar_pkg;

  typedef struct packed {
    logic        refill;
    logic [63:0] a_x_addr;
    logic [5:0]  a_x_id;
    logic [7:0]  way;
  } llc_desc_t;

  typedef struct packed {
    logic [5:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [0:0]  user;
  } llc_ar_chan_t;

endpackage

module axi_llc_refill_ar_master
  import axi_llc_refill_ar_pkg::*;
#(
  parameter int unsigned AddrWidth      = 64,
  parameter int unsigned IdWidth        = 6,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned BlockSize      = 8,
  parameter int unsigned MaxOutstanding = 4,
  parameter type         desc_t         = llc_desc_t,
  parameter type         ar_chan_t      = llc_ar_chan_t
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  desc_t    desc_i,
  input  logic     desc_valid_i,
  output logic     desc_ready_o,
  output desc_t    desc_o,
  output logic     desc_valid_o,
  input  logic     desc_ready_i,
  output ar_chan_t ar_chan_mst_o,
  output logic     ar_valid_o,
  input  logic     ar_ready_i,
  input  logic     refill_done_i,
  output logic     busy_o
);

  localparam int unsigned CntW    = $clog2(MaxOutstanding + 1);
  localparam int unsigned OffLog  = $clog2(BlockSize * DataWidth / 8);
  localparam int unsigned SizeLog = $clog2(DataWidth / 8);

  localparam logic [AddrWidth-1:0] LineMask =
    {AddrWidth{1'b1}} << OffLog;
  localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

  typedef enum logic {
    IDLE,
    ISSUE
  } state_e;

  state_e          state_q, state_d;
  desc_t           desc_q, desc_d;
  ar_chan_t        ar_q, ar_d;
  logic            ar_pend_q, ar_pend_d;
  logic            desc_pend_q, desc_pend_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic ar_hs;
  logic dsc_hs;

  assign ar_valid_o    = ar_pend_q;
  assign desc_valid_o  = desc_pend_q;
  assign ar_chan_mst_o = ar_q;
  assign desc_o        = desc_q;
  assign ar_hs         = ar_pend_q & ar_ready_i;
  assign dsc_hs        = desc_pend_q & desc_ready_i;
  assign busy_o        = (state_q != IDLE) || (cnt_q != '0);

  // Accept in IDLE, then hold AR and descriptor until both handshake.
  always_comb begin
    state_d      = state_q;
    desc_d       = desc_q;
    ar_d         = ar_q;
    ar_pend_d    = ar_pend_q;
    desc_pend_d  = desc_pend_q;
    desc_ready_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        desc_ready_o = !rst_i && (cnt_q < CntMax);
        if (desc_valid_i && desc_ready_o) begin
          desc_d       = desc_i;
          ar_d         = '0;
          ar_d.id      = desc_i.a_x_id;
          ar_d.addr    = desc_i.a_x_addr & LineMask;
          ar_d.len     = 8'(BlockSize - 1);
          ar_d.size    = 3'(SizeLog);
          ar_d.burst   = 2'b01;
          ar_d.cache   = 4'b0011;
          ar_pend_d    = desc_i.refill;
          desc_pend_d  = 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (ar_hs) ar_pend_d = 1'b0;
        if (dsc_hs) desc_pend_d = 1'b0;
        if (!ar_pend_d && !desc_pend_d) state_d = IDLE;
      end
    endcase
  end

  // Bursts in flight: up on AR handshake, down on consumed refill.
  always_comb begin
    cnt_d = cnt_q;
    case ({ar_hs, refill_done_i})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // State, payload and counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      desc_q      <= '0;
      ar_q        <= '0;
      ar_pend_q   <= 1'b0;
      desc_pend_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      desc_q      <= desc_d;
      ar_q        <= ar_d;
      ar_pend_q   <= ar_pend_d;
      desc_pend_q <= desc_pend_d;
      cnt_q       <= cnt_d;
    end
  end

`ifndef SYNTHESIS
  a_ar_refill_only : assert property (
    @(posedge clk_i) disable iff (rst_i)
    ar_valid_o |-> desc_q.refill);

  a_ar_stable : assert property (
    @(posedge clk_i) disable iff (rst_i)
    (ar_valid_o && !ar_ready_i) |=> $stable(ar_chan_mst_o));

  a_desc_stable : assert property (
    @(posedge clk_i) disable iff (rst_i)
    (desc_valid_o && !desc_ready_i) |=> $stable(desc_o));

  a_done_underflow : assert property (
    @(posedge clk_i) disable iff (rst_i)
    !(refill_done_i && cnt_q == '0));
`endif

endmodule
